a_channel_receiver: RTL and testbench

Receiving end of the 4-bit-opcode / 2-bit-beat / 8-bit-data "A" channel that the testbench driver produces. It accepts beats under a valid/ready handshake and assembles 1-, 2- or 4-beat messages into a 32-bit word. It checks beat sequencing and opcode legality, then presents each completed message on a one-entry output buffer with its own valid/ready handshake. Saturating message and error counters are exposed for end-of-test reporting.

---
 rtl/a_channel_receiver.sv | 141 ++++++++++++++
 tb/tb_a_channel_receiver.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a_channel_receiver.sv
// Receiver for the A channel: assembles 1/2/4-beat messages into a 32-bit word,
// checks beat order and opcode legality, and hands each message to a one-entry buffer.
module a_channel_receiver #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               a_valid,
    output logic               a_ready,
    input  logic [3:0]         a_opcode,
    input  logic [1:0]         a_beat,
    input  logic [7:0]         a_data,
    output logic               msg_valid,
    input  logic               msg_ready,
    output logic [3:0]         msg_opcode,
    output logic [1:0]         msg_len,
    output logic [31:0]        msg_data,
    output logic               err_valid,
    output logic [1:0]         err_code,
    output logic [COUNT_W-1:0] msg_count,
    output logic [COUNT_W-1:0] err_count
);

    // Handshakes: a transfer happens on a rising clk edge where valid && ready;
    // valid never waits on ready, and a producer holds its payload stable until it transfers.
    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    state_t      state_q, state_d;
    logic [1:0]  expect_q, expect_d;
    logic [3:0]  op_d;
    logic [1:0]  len_d;
    logic [31:0] data_d;
    logic [1:0]  err_d;
    logic        msg_done;
    logic        beat_acc;
    logic        op_legal;
    logic [1:0]  op_len;

    assign a_ready   = (state_q != HOLD);
    assign msg_valid = (state_q == HOLD);
    assign beat_acc  = a_valid && a_ready;

    always_comb begin
        op_legal = 1'b0;
        op_len   = 2'd0;
        case (a_opcode)
            4'h0: begin op_legal = 1'b1; op_len = 2'd3; end
            4'h1: begin op_legal = 1'b1; op_len = 2'd1; end
            4'h4: begin op_legal = 1'b1; op_len = 2'd0; end
            default: begin op_legal = 1'b0; op_len = 2'd0; end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        expect_d = expect_q;
        op_d     = msg_opcode;
        len_d    = msg_len;
        data_d   = msg_data;
        err_d    = 2'd0;
        msg_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (beat_acc) begin
                    if (!op_legal) begin
                        err_d = 2'd1;
                    end else if (a_beat != 2'd0) begin
                        err_d = 2'd2;
                    end else begin
                        data_d   = {24'h0, a_data};
                        op_d     = a_opcode;
                        len_d    = op_len;
                        expect_d = 2'd1;
                        state_d  = (op_len == 2'd0) ? HOLD : COLLECT;
                    end
                end
            end
            COLLECT: begin
                // Opcode change wins over a bad beat index; either way the beat is dropped.
                if (beat_acc) begin
                    if (a_opcode != msg_opcode) begin
                        err_d   = 2'd3;
                        state_d = IDLE;
                    end else if (a_beat != expect_q) begin
                        err_d   = 2'd2;
                        state_d = IDLE;
                    end else begin
                        data_d[{a_beat, 3'b000} +: 8] = a_data;
                        expect_d = expect_q + 2'd1;
                        if (a_beat == msg_len) begin
                            state_d = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (msg_ready) begin
                    state_d  = IDLE;
                    msg_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            expect_q   <= 2'd0;
            msg_opcode <= 4'h0;
            msg_len    <= 2'd0;
            msg_data   <= 32'h0;
            err_valid  <= 1'b0;
            err_code   <= 2'd0;
        end else begin
            state_q    <= state_d;
            expect_q   <= expect_d;
            msg_opcode <= op_d;
            msg_len    <= len_d;
            msg_data   <= data_d;
            err_valid  <= (err_d != 2'd0);
            err_code   <= err_d;
        end
    end

    // Each counter counts its own event: a message handshake, or a visible error pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            msg_count <= '0;
            err_count <= '0;
        end else begin
            if (msg_done && !(&msg_count)) begin
                msg_count <= msg_count + COUNT_W'(1);
            end
            if (err_valid && !(&err_count)) begin
                err_count <= err_count + COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_a_channel_receiver.sv
// Bench for a_channel_receiver: directed scenarios plus random traffic, checked by a
// message-level reference model feeding expected queues that a monitor drains.
module tb_a_channel_receiver;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          a_valid;
    logic          a_ready;
    logic [3:0]    a_opcode;
    logic [1:0]    a_beat;
    logic [7:0]    a_data;
    logic          msg_valid;
    logic          msg_ready;
    logic [3:0]    msg_opcode;
    logic [1:0]    msg_len;
    logic [31:0]   msg_data;
    logic          err_valid;
    logic [1:0]    err_code;
    logic [CW-1:0] msg_count;
    logic [CW-1:0] err_count;

    a_channel_receiver #(.COUNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_beat(a_beat), .a_data(a_data),
        .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_opcode(msg_opcode), .msg_len(msg_len),
        .msg_data(msg_data), .err_valid(err_valid), .err_code(err_code),
        .msg_count(msg_count), .err_count(err_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // scoreboard: {opcode, len, data} per expected message, and expected error codes
    logic [37:0] exp_q[$];
    logic [1:0]  err_q[$];
    bit          holding = 1'b0;
    int          exp_msg_cnt = 0;
    int          exp_err_cnt = 0;
    bit          rdy_rand = 1'b0;

    // reference model state: bytes collected so far for the message in progress
    bit          in_msg = 1'b0;
    logic [3:0]  m_op;
    int          m_n;
    int          m_got;
    logic [7:0]  m_bytes[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int beats_for(input logic [3:0] op);
        case (op)
            4'h0: return 4;
            4'h1: return 2;
            4'h4: return 1;
            default: return 0;
        endcase
    endfunction

    task automatic push_msg();
        logic [31:0] word;
        word = 32'h0;
        for (int k = 0; k < m_n; k++) word = word | (32'(m_bytes[k]) << (8 * k));
        exp_q.push_back({m_op, 2'(m_n - 1), word});
        holding = 1'b1;
        in_msg  = 1'b0;
    endtask

    // called once per accepted beat
    task automatic model_beat(input logic [3:0] op, input logic [1:0] b, input logic [7:0] d);
        if (!in_msg) begin
            if (beats_for(op) == 0) begin
                err_q.push_back(2'd1);
            end else if (b != 2'd0) begin
                err_q.push_back(2'd2);
            end else begin
                m_op  = op;
                m_n   = beats_for(op);
                for (int k = 0; k < 4; k++) m_bytes[k] = 8'h0;
                m_bytes[0] = d;
                m_got = 1;
                in_msg = 1'b1;
                if (m_got == m_n) push_msg();
            end
        end else begin
            if (op != m_op) begin
                err_q.push_back(2'd3);
                in_msg = 1'b0;
            end else if (int'(b) != m_got) begin
                err_q.push_back(2'd2);
                in_msg = 1'b0;
            end else begin
                m_bytes[b] = d;
                m_got++;
                if (m_got == m_n) push_msg();
            end
        end
    endtask

    // driver: present one beat, wait (bounded) for acceptance, leave a_valid low afterwards
    task automatic send_beat(input logic [3:0] op, input logic [1:0] b, input logic [7:0] d);
        bit ok;
        a_valid  = 1'b1;
        a_opcode = op;
        a_beat   = b;
        a_data   = d;
        ok = 1'b0;
        for (int t = 0; t < 64 && !ok; t++) begin
            @(negedge clk);
            if (a_ready) ok = 1'b1;
        end
        if (!ok) begin
            check("a_ready_timeout", 0, 1);
            a_valid = 1'b0;
        end else begin
            @(posedge clk);
            model_beat(op, b, d);
            #1 a_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n  = 1'b0;
        a_valid  = 1'b0;
        holding  = 1'b0;
        in_msg   = 1'b0;
        exp_q.delete();
        err_q.delete();
        exp_msg_cnt = 0;
        exp_err_cnt = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // monitor: compares DUT outputs against the expected queues every cycle
    initial begin
        logic [37:0] front;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                check("reset_outputs",
                      {a_ready, msg_valid, msg_opcode, msg_len, msg_data, err_valid, err_code, msg_count, err_count},
                      {1'b1, 50'h0});
            end else begin
                check("msg_count", msg_count, exp_msg_cnt);
                check("err_count", err_count, exp_err_cnt);
                check("a_ready", a_ready, !holding);
                check("msg_valid", msg_valid, holding);
                if (msg_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_msg", {msg_opcode, msg_len, msg_data}, 0);
                    end else begin
                        front = exp_q[0];
                        check("msg_opcode", msg_opcode, front[37:34]);
                        check("msg_len", msg_len, front[33:32]);
                        check("msg_data", msg_data, front[31:0]);
                        if (msg_ready) begin
                            void'(exp_q.pop_front());
                            holding = 1'b0;
                            if (exp_msg_cnt < CMAX) exp_msg_cnt++;
                        end
                    end
                end
                if (err_valid) begin
                    if (err_q.size() == 0) begin
                        check("unexpected_err", err_code, 0);
                    end else begin
                        check("err_code", err_code, err_q.pop_front());
                    end
                    if (exp_err_cnt < CMAX) exp_err_cnt++;
                end else begin
                    check("err_code_idle", err_code, 0);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) msg_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] op, o;
        logic [1:0] b;
        int n;
        reset_n   = 1'b0;
        a_valid   = 1'b0;
        a_opcode  = 4'h0;
        a_beat    = 2'd0;
        a_data    = 8'h0;
        msg_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        idle_cycles(1);

        // PUT, back-to-back beats
        send_beat(4'h0, 2'd0, 8'h11);
        send_beat(4'h0, 2'd1, 8'h22);
        send_beat(4'h0, 2'd2, 8'h33);
        send_beat(4'h0, 2'd3, 8'h44);
        idle_cycles(3);
        check("put_msg_count", msg_count, 1);

        // GET held by a stalled consumer
        msg_ready = 1'b0;
        send_beat(4'h4, 2'd0, 8'hA5);
        idle_cycles(3);
        msg_ready = 1'b1;
        idle_cycles(3);
        check("get_msg_count", msg_count, 2);

        // illegal opcode, then PUT_HALF
        send_beat(4'h7, 2'd0, 8'h55);
        send_beat(4'h1, 2'd0, 8'h01);
        send_beat(4'h1, 2'd1, 8'h02);
        idle_cycles(3);

        // skipped beat, then stray beat from IDLE
        send_beat(4'h0, 2'd0, 8'hAA);
        send_beat(4'h0, 2'd2, 8'hBB);
        send_beat(4'h1, 2'd1, 8'hCC);
        idle_cycles(3);
        check("seq_err_count", err_count, 3);

        // opcode change mid-message
        send_beat(4'h0, 2'd0, 8'h10);
        send_beat(4'h1, 2'd1, 8'h20);
        idle_cycles(3);

        // random traffic with a randomly stalling consumer
        rdy_rand = 1'b1;
        for (int m = 0; m < 80; m++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: op = 4'h0;
                3, 4, 5: op = 4'h1;
                6, 7, 8: op = 4'h4;
                default: op = 4'($urandom_range(0, 15));
            endcase
            n = (beats_for(op) == 0) ? 1 : beats_for(op);
            for (int k = 0; k < n; k++) begin
                b = 2'(k);
                o = op;
                case ($urandom_range(0, 15))
                    0: b = 2'($urandom_range(0, 3));
                    1: o = 4'($urandom_range(0, 15));
                    default: ;
                endcase
                send_beat(o, b, 8'($urandom_range(0, 255)));
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        end
        rdy_rand = 1'b0;
        msg_ready = 1'b1;
        idle_cycles(4);
        check("rand_drain_msgs", exp_q.size(), 0);
        check("rand_drain_errs", err_q.size(), 0);

        // reset in the middle of a PUT
        send_beat(4'h0, 2'd0, 8'h01);
        send_beat(4'h0, 2'd1, 8'h02);
        do_reset();
        idle_cycles(1);
        check("post_reset_counts", {msg_count, err_count}, 0);

        // message counter saturation
        for (int i = 0; i < (1 << CW) + 2; i++) send_beat(4'h4, 2'd0, 8'(i));
        idle_cycles(3);
        check("msg_count_sat", msg_count, CMAX);

        check("final_msgs_drained", exp_q.size(), 0);
        check("final_errs_drained", err_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
